// File: rtl/counter_mod.sv
// Parametrised up/down modulo counter with synchronous load, optional saturation,
// combinational terminal count and a registered wrap pulse.
module counter_mod #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  output logic             co,
  output logic             wrap,
  output logic [WIDTH-1:0] counter
);

  generate
    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_param
      $error("counter_mod: illegal WIDTH/MODULUS combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MODW = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic [WIDTH-1:0] w_term;
  logic             w_at_term;
  logic             w_din_ok;

  // Terminal value follows direction combinationally; no path from en/ld/din.
  assign w_term    = up ? MAXV : '0;
  assign w_at_term = (r_count == w_term);
  assign w_din_ok  = ({1'b0, din} < MODW);

  assign co      = w_at_term;
  assign wrap    = r_wrap;
  assign counter = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (ld) begin
        // Out-of-range loads clamp so the count never leaves 0..MODULUS-1.
        r_count <= w_din_ok ? din : MAXV;
      end else if (en) begin
        if (!w_at_term) begin
          r_count <= up ? r_count + ONE : r_count - ONE;
        end else if (!SATURATE) begin
          r_count <= up ? '0 : MAXV;
          r_wrap  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_mod.sv
// Bench for counter_mod: table-driven vectors and hand sequences feeding a scoreboard queue.
module tb_counter_mod;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 0: default, 1: MODULUS=10, 2: saturating, 3/4: cascade lower/upper
  logic       d_en = 0, d_up = 0, d_ld = 0;  logic [3:0] d_din = '0;
  logic       m_en = 0, m_up = 0, m_ld = 0;  logic [3:0] m_din = '0;
  logic       s_en = 0, s_up = 0, s_ld = 0;  logic [3:0] s_din = '0;
  logic       c_en = 0;
  logic       d_co, d_wrap, m_co, m_wrap, s_co, s_wrap, cl_co, cl_wrap, ch_co, ch_wrap;
  logic [3:0] d_cnt, m_cnt, s_cnt, cl_cnt, ch_cnt;
  logic       ch_en;
  assign ch_en = c_en & cl_co;

  counter_mod u_d (.clk(clk), .rst(rst), .en(d_en), .up(d_up), .ld(d_ld), .din(d_din),
                   .co(d_co), .wrap(d_wrap), .counter(d_cnt));
  counter_mod #(.WIDTH(4), .MODULUS(10)) u_m (.clk(clk), .rst(rst), .en(m_en), .up(m_up),
                   .ld(m_ld), .din(m_din), .co(m_co), .wrap(m_wrap), .counter(m_cnt));
  counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b1)) u_s (.clk(clk), .rst(rst), .en(s_en),
                   .up(s_up), .ld(s_ld), .din(s_din), .co(s_co), .wrap(s_wrap), .counter(s_cnt));
  counter_mod u_cl (.clk(clk), .rst(rst), .en(c_en), .up(1'b1), .ld(1'b0), .din(4'd0),
                    .co(cl_co), .wrap(cl_wrap), .counter(cl_cnt));
  counter_mod u_ch (.clk(clk), .rst(rst), .en(ch_en), .up(1'b1), .ld(1'b0), .din(4'd0),
                    .co(ch_co), .wrap(ch_wrap), .counter(ch_cnt));

  typedef struct {
    int    sel;
    int    cnt;
    int    co;
    int    wrap;
    string tag;
  } exp_t;

  typedef struct {
    int en; int up; int ld; int din;
    int cnt; int co; int wrap;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int act_cnt(input int sel);
    case (sel)
      0: return int'(d_cnt);
      1: return int'(m_cnt);
      2: return int'(s_cnt);
      3: return int'(cl_cnt);
      default: return int'(ch_cnt);
    endcase
  endfunction

  function automatic int act_co(input int sel);
    case (sel)
      0: return int'(d_co);
      1: return int'(m_co);
      2: return int'(s_co);
      3: return int'(cl_co);
      default: return int'(ch_co);
    endcase
  endfunction

  function automatic int act_wrap(input int sel);
    case (sel)
      0: return int'(d_wrap);
      1: return int'(m_wrap);
      2: return int'(s_wrap);
      3: return int'(cl_wrap);
      default: return int'(ch_wrap);
    endcase
  endfunction

  task automatic push(input int sel, input int cnt, input int co, input int wrap, input string tag);
    exp_t e;
    e.sel = sel; e.cnt = cnt; e.co = co; e.wrap = wrap; e.tag = tag;
    sbq.push_back(e);
  endtask

  // Advance one edge, then drain the scoreboard against the settled outputs.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({e.tag, ".counter"}, act_cnt(e.sel), e.cnt);
      chk({e.tag, ".co"},      act_co(e.sel),  e.co);
      chk({e.tag, ".wrap"},    act_wrap(e.sel), e.wrap);
    end
  endtask

  initial begin
    // en, up, ld, din -> counter, co, wrap (MODULUS=10 instance)
    vt.push_back('{1,1,0,0, 1,0,0});
    vt.push_back('{1,1,0,0, 2,0,0});
    vt.push_back('{1,1,0,0, 3,0,0});
    vt.push_back('{1,1,0,0, 4,0,0});
    vt.push_back('{1,1,0,0, 5,0,0});
    vt.push_back('{1,1,0,0, 6,0,0});
    vt.push_back('{1,1,0,0, 7,0,0});
    vt.push_back('{1,1,0,0, 8,0,0});
    vt.push_back('{1,1,0,0, 9,1,0});
    vt.push_back('{1,1,0,0, 0,0,1});
    vt.push_back('{1,1,0,0, 1,0,0});
    vt.push_back('{1,1,0,0, 2,0,0});
    vt.push_back('{1,0,0,0, 1,0,0});
    vt.push_back('{1,0,0,0, 0,1,0});
    vt.push_back('{1,0,0,0, 9,0,1});
    vt.push_back('{1,0,0,0, 8,0,0});
    vt.push_back('{1,1,0,0, 9,1,0});
    vt.push_back('{1,1,1,7, 7,0,0});
    vt.push_back('{0,1,1,13,9,1,0});
    vt.push_back('{0,1,1,10,9,1,0});
    vt.push_back('{1,1,0,0, 0,0,1});
    vt.push_back('{0,1,0,0, 0,0,0});
    vt.push_back('{1,0,0,0, 9,0,1});
    vt.push_back('{1,0,1,3, 3,0,0});

    // Reset state: down-counting instances show co=1 while held in reset.
    #3;
    chk("rst.d.counter", int'(d_cnt), 0);
    chk("rst.d.wrap", int'(d_wrap), 0);
    chk("rst.d.co_down", int'(d_co), 1);
    chk("rst.m.counter", int'(m_cnt), 0);
    @(negedge clk);
    rst = 1'b1;

    // Up-count through a full wrap on the default instance.
    d_en = 1; d_up = 1;
    #1;
    chk("up.co_at0", int'(d_co), 0);
    for (int i = 1; i <= 17; i++) begin
      push(0, i % 16, (i % 16 == 15) ? 1 : 0, (i == 16) ? 1 : 0, $sformatf("up[%0d]", i));
      tick();
    end
    d_en = 0;

    // Table: non-power-of-two modulus, direction change, load priority and clamping.
    foreach (vt[i]) begin
      m_en = (vt[i].en != 0); m_up = (vt[i].up != 0); m_ld = (vt[i].ld != 0);
      m_din = 4'(vt[i].din);
      push(1, vt[i].cnt, vt[i].co, vt[i].wrap, $sformatf("vec[%0d]", i));
      tick();
    end
    m_en = 0; m_ld = 0;

    // Saturate: load 13, count up past 15, then reverse.
    s_ld = 1; s_din = 4'd13; s_up = 1;
    push(2, 13, 0, 0, "sat.ld");
    tick();
    s_ld = 0; s_en = 1;
    push(2, 14, 0, 0, "sat[14]"); tick();
    push(2, 15, 1, 0, "sat[15]"); tick();
    for (int i = 0; i < 3; i++) begin
      push(2, 15, 1, 0, $sformatf("sat.hold[%0d]", i));
      tick();
    end
    s_up = 0;
    push(2, 14, 0, 0, "sat.down");
    tick();
    s_en = 0;

    // Async reset between edges at counter=6, held over two enabled edges.
    d_ld = 1; d_din = 4'd6; d_up = 1;
    push(0, 6, 0, 0, "ar.ld6");
    tick();
    d_ld = 0; d_en = 1;
    #2;
    rst = 1'b0;
    #1;
    chk("ar.async.counter", int'(d_cnt), 0);
    chk("ar.async.wrap", int'(d_wrap), 0);
    for (int i = 0; i < 2; i++) begin
      push(0, 0, 0, 0, $sformatf("ar.held[%0d]", i));
      tick();
    end
    @(negedge clk);
    rst = 1'b1;
    // Same again while wrap is high: clear must drop wrap without an edge.
    d_ld = 1; d_din = 4'd15;
    push(0, 15, 1, 0, "ar.ld15");
    tick();
    d_ld = 0;
    push(0, 0, 0, 1, "ar.wrap");
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("ar.async.wrap_clear", int'(d_wrap), 0);
    d_en = 0;
    @(negedge clk);
    rst = 1'b1;

    // Cascade: 40 enabled edges reach 0x28, then 7 more to 0x2F and freeze.
    c_en = 1;
    for (int i = 1; i <= 47; i++) begin
      push(3, i % 16, (i % 16 == 15) ? 1 : 0, (i % 16 == 0) ? 1 : 0, $sformatf("cas.lo[%0d]", i));
      push(4, i / 16, 0, 0, $sformatf("cas.hi[%0d]", i));
      tick();
      if (i == 40) chk("cas.0x28", {28'd0, ch_cnt, cl_cnt}, 32'h28);
    end
    c_en = 0;
    for (int i = 0; i < 3; i++) begin
      push(3, 15, 1, 0, $sformatf("cas.frz.lo[%0d]", i));
      push(4, 2, 0, 0, $sformatf("cas.frz.hi[%0d]", i));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
